// File: rtl/serial_subtractor.sv
// Multi-cycle A - B - d_in subtractor: STEP bits per clock, LSB slice first,
// with a registered borrow carried between slices and a start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             d_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             d_out,
  output logic             ovf
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
      $error("serial_subtractor: STEP must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic [STEP:0]    slice;
  logic [WIDTH-1:0] res_next;
  logic             slice_ovf;
  logic             last;

  always_comb begin
    slice     = {1'b0, a_sh[STEP-1:0]} - {1'b0, b_sh[STEP-1:0]} - {{STEP{1'b0}}, borrow};
    res_next  = (res_sh >> STEP) | (WIDTH'(slice[STEP-1:0]) << (WIDTH - STEP));
    // Operand signs differ and result sign differs from the minuend; equivalent to
    // borrow-in XOR borrow-out of the top bit of the final slice.
    slice_ovf = (a_sh[STEP-1] ^ b_sh[STEP-1]) & (slice[STEP-1] ^ a_sh[STEP-1]);
    last      = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      d_out  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            borrow <= d_in;
            res_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> STEP;
          b_sh   <= b_sh >> STEP;
          res_sh <= res_next;
          borrow <= slice[STEP];
          cnt    <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res_next;
            d_out <= slice[STEP];
            ovf   <= slice_ovf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at STEP = 1, 4 and 8 (WIDTH = 8).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       d_in = 1'b0;
  logic [2:0] start_v = '0;
  logic [2:0] busy_v, done_v, dout_v, ovf_v;
  logic [7:0] diff_v [3];

  int n_vec  = 0;
  int n_fail = 0;
  localparam int NS [3] = '{8, 2, 1};

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .A(a_in), .B(b_in), .d_in(d_in),
    .busy(busy_v[0]), .done(done_v[0]), .diff(diff_v[0]), .d_out(dout_v[0]), .ovf(ovf_v[0]));
  serial_subtractor #(.WIDTH(8), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .A(a_in), .B(b_in), .d_in(d_in),
    .busy(busy_v[1]), .done(done_v[1]), .diff(diff_v[1]), .d_out(dout_v[1]), .ovf(ovf_v[1]));
  serial_subtractor #(.WIDTH(8), .STEP(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .A(a_in), .B(b_in), .d_in(d_in),
    .busy(busy_v[2]), .done(done_v[2]), .diff(diff_v[2]), .d_out(dout_v[2]), .ovf(ovf_v[2]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       d;
    logic [7:0] diff;
    logic       dout;
    logic       ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int sel, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s (STEP inst %0d): got 0x%0h, expected 0x%0h", name, sel, got, exp);
    end
  endtask

  // Reference: unsigned and signed arithmetic computed in full-width integers.
  function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic d);
    int r, sr;
    logic [7:0] lo;
    r  = int'(a) - int'(b) - int'(d);
    sr = int'($signed(a)) - int'($signed(b)) - int'(d);
    lo = r[7:0];
    return {(sr > 127 || sr < -128), (r < 0), lo};
  endfunction

  task automatic start_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic d);
    a_in = a;
    b_in = b;
    d_in = d;
    start_v[sel] = 1'b1;
    tick();
    start_v[sel] = 1'b0;
    a_in = 8'hA5;
    b_in = 8'h5A;
    d_in = ~d;
  endtask

  // Waits for done; returns edges counted from the accepting edge and busy cycles seen.
  task automatic wait_done(input int sel, output int edges, output int busy_cnt);
    int both;
    edges    = 0;
    busy_cnt = 0;
    both     = 0;
    while (!done_v[sel] && edges < 20) begin
      if (busy_v[sel]) busy_cnt++;
      tick();
      edges++;
    end
    if (busy_v[sel] && done_v[sel]) both = 1;
    chk("busy_and_done_overlap", sel, both, 0);
    chk("done_timeout", sel, int'(done_v[sel]), 1);
  endtask

  task automatic run_check(input string name, input int sel, input logic [7:0] a, input logic [7:0] b,
                           input logic d, input logic [7:0] ediff, input logic edout, input logic eovf,
                           input bit timing);
    int edges, busy_cnt;
    start_op(sel, a, b, d);
    wait_done(sel, edges, busy_cnt);
    chk({name, "_diff"}, sel, int'(diff_v[sel]), int'(ediff));
    chk({name, "_dout"}, sel, int'(dout_v[sel]), int'(edout));
    chk({name, "_ovf"}, sel, int'(ovf_v[sel]), int'(eovf));
    if (timing) begin
      chk({name, "_latency"}, sel, edges, NS[sel]);
      chk({name, "_busy_cycles"}, sel, busy_cnt, NS[sel]);
    end
    tick();
    if (timing) chk({name, "_done_pulse"}, sel, int'(done_v[sel]), 0);
    $display("op %s inst=%0d A=%02h B=%02h d=%0d -> diff=%02h d_out=%0d ovf=%0d",
             name, sel, a, b, d, diff_v[sel], dout_v[sel], ovf_v[sel]);
  endtask

  initial begin
    int edges, busy_cnt;
    logic [9:0] r;
    logic [7:0] ra, rb, first_diff;
    logic rd;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 8'h5A, 1'b1, 8'hE1, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[8] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0};

    // Reset state
    #12;
    for (int s = 0; s < 3; s++) begin
      chk("reset_busy", s, int'(busy_v[s]), 0);
      chk("reset_done", s, int'(done_v[s]), 0);
      chk("reset_diff", s, int'(diff_v[s]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 9; i++)
        run_check($sformatf("vec%0d", i), s, vecs[i].a, vecs[i].b, vecs[i].d,
                  vecs[i].diff, vecs[i].dout, vecs[i].ovf, 1'b1);

    // Start while busy is ignored; operands are not resampled.
    start_op(0, 8'h10, 8'h01, 1'b0);
    tick();
    a_in = 8'h00;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    wait_done(0, edges, busy_cnt);
    chk("start_while_busy_diff", 0, int'(diff_v[0]), 8'h0F);
    chk("start_while_busy_latency", 0, edges + 2, NS[0]);
    tick();
    chk("start_while_busy_no_rerun", 0, int'(busy_v[0]), 0);

    // Reset mid-run aborts with no done pulse and clears outputs.
    start_op(0, 8'h20, 8'h01, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", 0, int'(busy_v[0]), 0);
    chk("midrun_reset_done", 0, int'(done_v[0]), 0);
    chk("midrun_reset_diff", 0, int'(diff_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done_v[0] || busy_v[0]) seen = 1;
      end
      chk("midrun_reset_no_done", 0, seen, 0);
    end

    // Back-to-back start in DONE: second done N+1 edges after the first.
    for (int s = 1; s < 3; s++) begin
      start_op(s, 8'h3C, 8'h5A, 1'b1);
      wait_done(s, edges, busy_cnt);
      first_diff = diff_v[s];
      chk("b2b_first_diff", s, int'(first_diff), 8'hE1);
      start_op(s, 8'h80, 8'h01, 1'b0);
      chk("b2b_hold_during_run", s, int'(diff_v[s]), 8'hE1);
      wait_done(s, edges, busy_cnt);
      chk("b2b_gap", s, edges + 1, NS[s] + 1);
      chk("b2b_second_diff", s, int'(diff_v[s]), 8'h7F);
      chk("b2b_second_ovf", s, int'(ovf_v[s]), 1);
      tick();
    end

    // Random sweep against the reference model.
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 300; i++) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rd = 1'($urandom_range(0, 1));
        r  = ref_sub(ra, rb, rd);
        run_check("rand", s, ra, rb, rd, r[7:0], r[8], r[9], 1'b0);
      end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
